// File: rtl/mesh_pkg.sv
// mesh_pkg: packet field layout, header type and injector state encoding for mesh terminals
package mesh_pkg;
    localparam int NXT_JMP_W = 8;
    localparam int ROW_W     = 4;
    localparam int COL_W     = 4;
    localparam int HDR_W     = NXT_JMP_W + ROW_W + COL_W + 1;
    localparam int PKT_MAX   = 64;

    typedef struct packed {
        logic [NXT_JMP_W-1:0] nxt_jump;
        logic [ROW_W-1:0]     row;
        logic [COL_W-1:0]     col;
        logic                 mode;
    } pkt_hdr_t;

    typedef enum logic {INIT, RUN} inj_state_e;

    // Header lands directly above a psz-HDR_W bit payload; caller truncates to its packet width
    function automatic logic [PKT_MAX-1:0] build_pkt(pkt_hdr_t hdr, logic [PKT_MAX-1:0] payload, int unsigned psz);
        return (PKT_MAX'(hdr) << (psz - HDR_W)) | payload;
    endfunction
endpackage

// File: rtl/mesh_sync_fifo.sv
// mesh_sync_fifo: first-word fall-through FIFO whose output holds the last head word when empty
module mesh_sync_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr,
    input  logic [W-1:0]               wdata,
    input  logic                       rd,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [W-1:0]  last;

    always_ff @(posedge clk)
        if (wr) mem[wp] <= wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    // Snapshot of the head so the output stays stable once the FIFO drains or is flushed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last <= '0;
        else if (count != '0) last <= mem[rp];
    end

    assign rdata = (count != '0) ? mem[rp] : last;
endmodule

// File: rtl/mesh_term_inject.sv
// mesh_term_inject: terminal request handshake, packet assembly and buffering toward a mesh port
module mesh_term_inject
    import mesh_pkg::*;
#(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int SELF_ROW   = 0,
    parameter int SELF_COL   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_row,
    input  logic [3:0]                    req_col,
    input  logic                          req_mode,
    input  logic [pckg_sz-18:0]           req_payload,
    input  logic                          flush,
    output logic                          pndng_i_in,
    output logic [pckg_sz-1:0]            data_out_i_in,
    input  logic                          popin,
    output logic [$clog2(fifo_depth):0]   count,
    output logic [15:0]                   sent_cnt,
    output logic [15:0]                   drop_cnt,
    output logic                          underflow
);
    localparam int CW = $clog2(fifo_depth) + 1;

    inj_state_e state;
    pkt_hdr_t   hdr;
    logic       accept, self_hit, wr, pop, empty;
    logic [pckg_sz-1:0] word;

    assign empty     = (count == '0);
    assign req_ready = (state == RUN) && (count < CW'(fifo_depth)) && !flush;
    assign accept    = req_valid && req_ready;
    assign self_hit  = (req_row == 4'(SELF_ROW)) && (req_col == 4'(SELF_COL));
    assign wr        = accept && !self_hit;
    assign pop       = popin && !empty && !flush;
    assign hdr       = '{nxt_jump: '0, row: req_row, col: req_col, mode: req_mode};
    assign word      = pckg_sz'(build_pkt(hdr, PKT_MAX'(req_payload), pckg_sz));
    assign pndng_i_in = !empty;

    mesh_sync_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .wr    (wr),
        .wdata (word),
        .rd    (pop),
        .rdata (data_out_i_in),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else state <= RUN;
    end

    // Flush wins over popin, so neither the sent count nor the underflow flag move in a flush cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_cnt  <= '0;
            drop_cnt  <= '0;
            underflow <= 1'b0;
        end else begin
            if (pop && sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 16'd1;
            if (accept && self_hit && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (popin && empty && !flush) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mesh_term_inject.sv
// tb_mesh_term_inject: directed self-checking bench for mesh_term_inject
module tb_mesh_term_inject;
    logic        clk = 0;
    logic        reset = 0;
    logic        req_valid = 0, req_ready, req_mode = 0, flush = 0, popin = 0;
    logic [3:0]  req_row = 0, req_col = 0;
    logic [22:0] req_payload = 0;
    logic        pndng_i_in, underflow;
    logic [39:0] data_out_i_in;
    logic [2:0]  count;
    logic [15:0] sent_cnt, drop_cnt;
    int n_chk = 0, n_fail = 0;

    mesh_term_inject dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_mode(req_mode), .req_payload(req_payload),
        .flush(flush), .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
        .count(count), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] mk(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [22:0] p);
        return {8'h00, r, c, m, p};
    endfunction

    task automatic send(input logic [22:0] p);
        req_valid = 1; req_row = 4'd1; req_col = 4'd1; req_mode = 0; req_payload = p;
        step();
        req_valid = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pndng", 64'(pndng_i_in), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_data", 64'(data_out_i_in), 0);
        chk("rst_cnts", {sent_cnt, drop_cnt, 15'd0, underflow}, 0);
        reset = 1;
        #1;
        chk("init_ready", 64'(req_ready), 0);
        step();
        chk("run_ready", 64'(req_ready), 1);

        req_valid = 1; req_row = 4'd2; req_col = 4'd3; req_mode = 1; req_payload = 23'h15A5A5;
        #1;
        chk("asm_pre_pndng", 64'(pndng_i_in), 0);
        step();
        req_valid = 0;
        chk("asm_pndng", 64'(pndng_i_in), 1);
        chk("asm_data", 64'(data_out_i_in), 64'h0023_95A5A5);
        chk("asm_count", 64'(count), 1);
        popin = 1; step(); popin = 0;
        chk("pop_pndng", 64'(pndng_i_in), 0);
        chk("pop_sent", 64'(sent_cnt), 1);
        chk("pop_hold", 64'(data_out_i_in), 64'h0023_95A5A5);

        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_row = 4'd1; req_col = 4'd1; req_mode = 0; req_payload = 23'(i);
            #1;
            chk("full_ready", 64'(req_ready), 1);
            step();
        end
        req_payload = 23'd4;
        #1;
        chk("full_ready_lo", 64'(req_ready), 0);
        chk("full_count", 64'(count), 4);
        chk("full_head", 64'(data_out_i_in), 64'(mk(1, 1, 0, 0)));
        popin = 1; step(); popin = 0;
        chk("full_pop_count", 64'(count), 3);
        chk("full_pop_ready", 64'(req_ready), 1);
        chk("full_pop_sent", 64'(sent_cnt), 2);
        step();
        req_valid = 0;
        chk("full_5th_count", 64'(count), 4);
        for (int i = 1; i < 5; i++) begin
            chk("full_order", 64'(data_out_i_in), 64'(mk(1, 1, 0, 23'(i))));
            popin = 1; step(); popin = 0;
        end
        chk("full_drain_count", 64'(count), 0);
        chk("full_drain_sent", 64'(sent_cnt), 6);

        send(23'd100);
        send(23'd101);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1; req_row = 4'd1; req_col = 4'd1; req_mode = 0; req_payload = 23'(102 + i);
            popin = 1;
            #1;
            chk("conc_data", 64'(data_out_i_in), 64'(mk(1, 1, 0, 23'(100 + i))));
            step();
            chk("conc_count", 64'(count), 2);
        end
        req_valid = 0; popin = 0;
        chk("conc_sent", 64'(sent_cnt), 16);
        for (int i = 110; i < 112; i++) begin
            chk("conc_tail", 64'(data_out_i_in), 64'(mk(1, 1, 0, 23'(i))));
            popin = 1; step(); popin = 0;
        end
        chk("conc_sent2", 64'(sent_cnt), 18);

        send(23'd7);
        req_valid = 1; req_row = 4'd0; req_col = 4'd1; req_mode = 0; req_payload = 23'h7FFFFF;
        #1;
        chk("self_ready", 64'(req_ready), 1);
        step();
        req_valid = 0;
        chk("self_drop", 64'(drop_cnt), 1);
        chk("self_count", 64'(count), 1);
        chk("self_pndng", 64'(pndng_i_in), 1);
        chk("self_data", 64'(data_out_i_in), 64'(mk(1, 1, 0, 23'd7)));
        popin = 1; step(); popin = 0;

        popin = 1; step(); popin = 0;
        chk("udf_flag", 64'(underflow), 1);
        chk("udf_sent", 64'(sent_cnt), 19);
        req_valid = 1; req_row = 4'd3; req_col = 4'd2; req_mode = 1; req_payload = 23'h1234;
        popin = 1; step(); popin = 0; req_valid = 0;
        chk("udf_wr_count", 64'(count), 1);
        chk("udf_wr_sent", 64'(sent_cnt), 19);
        chk("udf_wr_data", 64'(data_out_i_in), 64'(mk(3, 2, 1, 23'h1234)));
        popin = 1; step(); popin = 0;

        send(23'd1); send(23'd2); send(23'd3);
        flush = 1; popin = 1; req_valid = 1;
        #1;
        chk("flush_ready", 64'(req_ready), 0);
        step();
        flush = 0; popin = 0; req_valid = 0;
        chk("flush_count", 64'(count), 0);
        chk("flush_pndng", 64'(pndng_i_in), 0);
        chk("flush_cnts", {sent_cnt, drop_cnt, 15'd0, underflow}, {16'd20, 16'd1, 16'd1});

        send(23'd8); send(23'd9);
        chk("arst_pre", 64'(count), 2);
        #2 reset = 0;
        #1;
        chk("arst_pndng", 64'(pndng_i_in), 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_cnts", {sent_cnt, drop_cnt, 15'd0, underflow}, 0);
        #1 reset = 1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
